lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the ALU.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs a request/grant/response handshake with data memory and stalls the core while the access is in flight.
- Returns sign/zero-extended load data to writeback and reports alignment, illegal-width and timeout faults.

Parameters:
- TIMEOUT, 16, max cycles in WAIT for mem_rvalid after grant; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  EX stage presents a memory op this cycle
- is_load  input  1  op is a load
- is_store  input  1  op is a store
- funct3  input  3  RISC-V width: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010)
- addr  input  32  effective address (ALU result)
- store_data  input  32  rs2 value
- busy  output  1  stall to core
- done  output  1  one-cycle completion pulse
- rd_data  output  32  extended load result
- fault  output  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3; valid with done
- mem_req  output  1  memory request
- mem_we  output  1  1 = write
- mem_addr  output  32  word address {addr[31:2],2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte enables
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read word

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; all outputs 0, including rd_data and fault.
  - mem_req drops immediately even mid-transaction; no done is issued for an aborted op.
- Valid op = start & (is_load ^ is_store). start with both or neither flag set is ignored.
- busy = (state != IDLE && state != DONE) | (state == IDLE & valid op), so the core stalls in the same cycle it presents the op.
- IDLE, on valid op:
  - Latch addr, store_data, funct3 and type.
  - Fault check:
    - Illegal funct3: load 011/110/111, store anything other than 000/001/010 -> fault 11.
    - Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0 -> fault 01.
  - On fault go to DONE with no memory request. Otherwise go to REQ.
- REQ:
  - mem_req=1; mem_we, mem_addr, mem_wdata and mem_wstrb are stable and held until mem_gnt.
  - On gnt: store -> DONE; load -> WAIT, with the timeout counter cleared.
  - mem_rvalid in REQ is ignored.
- WAIT:
  - mem_req=0; the counter increments each cycle.
  - mem_rvalid -> extract, register rd_data, go to DONE.
  - If TIMEOUT != 0 and counter reaches TIMEOUT with no rvalid -> DONE with fault 10; rd_data is unchanged.
  - If rvalid arrives in the same cycle the counter expires, rvalid wins.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - start is ignored in DONE.
  - fault is held until the next done. rd_data is held until the next successful load.
- Store encoding, with b=addr[1:0]:
  - SB: wstrb = 0001<<b, wdata = {4{data[7:0]}}.
  - SH: wstrb = 0011<<(addr[1]*2), wdata = {2{data[15:0]}}.
  - SW: wstrb = 1111, wdata = data.
- Load extraction:
  - Shift the word right by 8*b.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Minimum latency from start to done:
  - store with immediate gnt: 3 cycles;
  - load with gnt then rvalid on the next cycle: 4 cycles;
  - fault: 2 cycles.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, gnt on first REQ cycle -> mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, done on cycle 3 with fault=00, busy high cycles 1-2.
- SB addr=0x103, data=0x000000A5, gnt delayed 3 cycles -> wstrb=1000, wdata=0xA5A5A5A5 held stable for all 4 REQ cycles; one done pulse.
- LB addr=0x202 with rdata=0x80FF7F01 -> rd_data=0xFFFFFFFF; LBU at the same address -> 0x000000FF; LH at 0x202 -> 0xFFFF80FF; LHU -> 0x000080FF.
- LW addr=0x201 -> no mem_req ever, done on cycle 2 with fault=01; SW with funct3=011 -> fault=11.
- LW with gnt but no rvalid, TIMEOUT=16 -> done with fault=10 after 16 WAIT cycles and rd_data unchanged; repeat with rvalid arriving in the expiry cycle -> fault=00 and data captured.
- rst_n pulsed low during WAIT -> mem_req, busy and done all 0 immediately, no done pulse; start with is_load=is_store=1 -> ignored and busy stays 0.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: EX effective address + rs2 in, req/gnt/rvalid data-memory handshake, extended load data out.
// Latency: start->done 2 cycles on a fault, 3 for a store, 4 for a load; memory grant/response delays add 1:1.
// Backpressure: busy stalls the core until done; mem_req and its payload are held until mem_gnt.
module lsu_mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] rd_data,
   output logic [1:0]  fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   // Wide enough to count 0..TIMEOUT-1; at least one bit when the timeout is disabled.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [1:0] FLT_OK       = 2'b00;
   localparam logic [1:0] FLT_MISALIGN = 2'b01;
   localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
   localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     addr_q, addr_d;
   logic [2:0]      f3_q, f3_d;
   logic            we_q, we_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      wstrb_q, wstrb_d;
   logic [31:0]     rd_q, rd_d;
   logic [1:0]      fault_q, fault_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            valid_op;
   logic            illegal;
   logic            misalign;
   logic [3:0]      st_wstrb;
   logic [31:0]     st_wdata;
   logic [31:0]     ld_shift;
   logic [31:0]     ld_ext;

   // Decode the op presented by EX: legality, alignment and store lane encoding.
   always_comb begin
      valid_op = start & (is_load ^ is_store);
      illegal  = 1'b0;
      misalign = 1'b0;
      st_wstrb = 4'b1111;
      st_wdata = store_data;

      if (is_load) begin
         case (funct3)
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            default:                illegal = 1'b0;
         endcase
      end else begin
         illegal = !((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010));
      end

      // Only legal encodings reach memory, so the width bits alone decide alignment.
      case (funct3)
         3'b001, 3'b101: misalign = addr[0];
         3'b010:         misalign = |addr[1:0];
         default:        misalign = 1'b0;
      endcase

      case (funct3[1:0])
         2'b00: begin
            st_wstrb = 4'b0001 << addr[1:0];
            st_wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{store_data[15:0]}};
         end
         default: begin
            st_wstrb = 4'b1111;
            st_wdata = store_data;
         end
      endcase
   end

   // Align the returned word to the addressed byte and sign/zero-extend by width.
   always_comb begin
      ld_shift = mem_rdata >> {addr_q[1:0], 3'b000};
      ld_ext   = ld_shift;
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'b100:  ld_ext = {24'h000000, ld_shift[7:0]};
         3'b101:  ld_ext = {16'h0000, ld_shift[15:0]};
         default: ld_ext = ld_shift;
      endcase
   end

   // Next state, latched op fields, result registers and the core/memory-facing outputs.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      f3_d    = f3_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rd_d    = rd_q;
      fault_d = fault_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (valid_op) begin
               addr_d  = addr;
               f3_d    = funct3;
               we_d    = is_store;
               wdata_d = is_store ? st_wdata : 32'h0;
               wstrb_d = is_store ? st_wstrb : 4'b0000;
               if (illegal) begin
                  fault_d = FLT_ILLEGAL;
                  state_d = S_DONE;
               end else if (misalign) begin
                  fault_d = FLT_MISALIGN;
                  state_d = S_DONE;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            // A response seen here belongs to nobody; only the grant matters.
            if (mem_gnt) begin
               if (we_q) begin
                  fault_d = FLT_OK;
                  state_d = S_DONE;
               end else begin
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // Response beats the timeout when both land in the same cycle.
            if (mem_rvalid) begin
               rd_d    = ld_ext;
               fault_d = FLT_OK;
               state_d = S_DONE;
            end else if ((TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1)) begin
               fault_d = FLT_TIMEOUT;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy      = (state_q == S_REQ) || (state_q == S_WAIT) || ((state_q == S_IDLE) && valid_op);
      done      = (state_q == S_DONE);
      mem_req   = (state_q == S_REQ);
      mem_we    = mem_req & we_q;
      mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
      mem_wdata = mem_req ? wdata_q : 32'h0;
      mem_wstrb = mem_req ? wstrb_q : 4'b0000;
      rd_data   = rd_q;
      fault     = fault_q;
   end

   // FSM state register; reset abandons any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latched op fields, timeout counter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= 32'h0;
         f3_q    <= 3'b000;
         we_q    <= 1'b0;
         wdata_q <= 32'h0;
         wstrb_q <= 4'b0000;
         rd_q    <= 32'h0;
         fault_q <= FLT_OK;
         cnt_q   <= '0;
      end else begin
         addr_q  <= addr_d;
         f3_q    <= f3_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rd_q    <= rd_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
